div_ramp_ctrl: RTL and testbench

DIV_RAMP_CTRL -- requirements
Module: div_ramp_ctrl

---
 rtl/div_ramp_ctrl.sv | 147 ++++++++++++++
 tb/tb_div_ramp_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ramp_ctrl
// Description : Ramps a clock divider's divide value toward a requested
//               target in bounded steps, retargeting only at divider period
//               boundaries, with settle time, abort and edge-loss timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ramp_ctrl #(
   parameter int unsigned DEFAULT_DIV    = 4,
   parameter int unsigned DIV_MIN        = 2,
   parameter int unsigned DIV_MAX        = 1024,
   parameter int unsigned STEP           = 4,
   parameter int unsigned SETTLE_PERIODS = 2,
   parameter int unsigned TIMEOUT        = 4096
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_div,
   input  logic        abort,
   input  logic        div_clk_out,
   output logic [31:0] div_val,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Counter widths: settle counter holds 0..SETTLE_PERIODS, timeout
   // counter holds 0..TIMEOUT-1.
   localparam int unsigned SW = (SETTLE_PERIODS < 1) ? 1 : $clog2(SETTLE_PERIODS + 1);
   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   localparam logic [31:0]    DEFAULT_VAL   = 32'(DEFAULT_DIV);
   localparam logic [31:0]    MIN_VAL       = 32'(DIV_MIN);
   localparam logic [31:0]    MAX_VAL       = 32'(DIV_MAX);
   localparam logic [31:0]    STEP_VAL      = 32'(STEP);
   localparam logic [SW-1:0]  SETTLE_ONE    = SW'(1);
   localparam logic [SW-1:0]  SETTLE_RELOAD = SW'(SETTLE_PERIODS);
   localparam logic [TW-1:0]  TMO_LAST      = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]  TMO_ONE       = TW'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   state_t         state_q;
   logic [31:0]    div_val_q;
   logic [31:0]    target_q;
   logic [SW-1:0]  settle_q;
   logic [TW-1:0]  tmo_q;
   logic           prev_q;
   logic           done_q;
   logic           err_q;

   logic           div_edge;
   logic           req_in_range;
   logic           step_up;
   logic [31:0]    gap;
   logic [31:0]    delta;
   logic [31:0]    div_val_d;

   // Rising edge of the divider output marks a period boundary.
   assign div_edge     = div_clk_out & ~prev_q;
   assign req_in_range = (req_div >= MIN_VAL) && (req_div <= MAX_VAL);

   // Next divide value one step toward the target; delta never exceeds the
   // gap, so the result cannot overshoot or wrap.
   always_comb begin
      step_up   = (target_q > div_val_q);
      gap       = step_up ? (target_q - div_val_q) : (div_val_q - target_q);
      delta     = (gap > STEP_VAL) ? STEP_VAL : gap;
      div_val_d = step_up ? (div_val_q + delta) : (div_val_q - delta);
   end

   // Controller state machine with registered done/err pulses.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         div_val_q <= DEFAULT_VAL;
         target_q  <= '0;
         settle_q  <= '0;
         tmo_q     <= '0;
         prev_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         prev_q <= div_clk_out;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  if (!req_in_range) begin
                     err_q <= 1'b1;
                  end else if (req_div == div_val_q) begin
                     done_q <= 1'b1;
                  end else begin
                     target_q <= req_div;
                     // First edge after acceptance applies the first step.
                     settle_q <= SETTLE_ONE;
                     tmo_q    <= '0;
                     state_q  <= ST_RAMP;
                  end
               end
            end
            ST_RAMP: begin
               if (abort) begin
                  // Abort beats a coincident edge: no step, no pulse.
                  state_q <= ST_IDLE;
               end else if (div_edge) begin
                  tmo_q <= '0;
                  if (settle_q > SETTLE_ONE) begin
                     settle_q <= settle_q - SETTLE_ONE;
                  end else begin
                     div_val_q <= div_val_d;
                     settle_q  <= SETTLE_RELOAD;
                     if (div_val_d == target_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                     end
                  end
               end else if (tmo_q == TMO_LAST) begin
                  // Divider stopped toggling: give up, keep current value.
                  err_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RAMP);
   assign div_val   = div_val_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ramp_ctrl
// Description : Self-checking bench for div_ramp_ctrl: behavioural model
//               compared every cycle, directed scenarios, random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ramp_ctrl;

   localparam int unsigned DEFAULT_DIV    = 4;
   localparam int unsigned DIV_MIN        = 2;
   localparam int unsigned DIV_MAX        = 1024;
   localparam int unsigned STEP           = 4;
   localparam int unsigned SETTLE_PERIODS = 2;
   localparam int unsigned TIMEOUT        = 4096;

   logic        clk_in = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_div;
   logic        abort;
   logic        div_clk_out;
   logic [31:0] div_val;
   logic        busy;
   logic        done;
   logic        err;

   int vectors     = 0;
   int miscompares = 0;

   div_ramp_ctrl #(
      .DEFAULT_DIV   (DEFAULT_DIV),
      .DIV_MIN       (DIV_MIN),
      .DIV_MAX       (DIV_MAX),
      .STEP          (STEP),
      .SETTLE_PERIODS(SETTLE_PERIODS),
      .TIMEOUT       (TIMEOUT)
   ) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_div    (req_div),
      .abort      (abort),
      .div_clk_out(div_clk_out),
      .div_val    (div_val),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk_in = ~clk_in;

   // ------------------------------------------------------------------
   // Behavioural model: "ramping" flag, edges still to skip before the
   // next step, and quiet cycles since the last edge/acceptance.
   // ------------------------------------------------------------------
   typedef struct packed {
      logic        ramping;
      logic [31:0] dv;
      logic [31:0] tgt;
      logic [31:0] skip_edges;
      logic [31:0] quiet;
      logic        prev;
      logic        done;
      logic        err;
   } mstate_t;

   mstate_t ms;

   function automatic logic [31:0] toward(input logic [31:0] cur, input logic [31:0] tgt);
      if (tgt > cur) return (tgt - cur > STEP) ? cur + STEP : tgt;
      else           return (cur - tgt > STEP) ? cur - STEP : tgt;
   endfunction

   function automatic mstate_t mreset();
      mstate_t r;
      r = '0;
      r.dv = DEFAULT_DIV;
      return r;
   endfunction

   function automatic mstate_t mnext(input mstate_t s, input logic dco, input logic rv,
                                     input logic [31:0] rd, input logic ab);
      mstate_t n;
      logic    e;
      n      = s;
      e      = dco & ~s.prev;
      n.prev = dco;
      n.done = 1'b0;
      n.err  = 1'b0;
      if (!s.ramping) begin
         if (rv) begin
            if (rd < DIV_MIN || rd > DIV_MAX) n.err = 1'b1;
            else if (rd == s.dv)              n.done = 1'b1;
            else begin
               n.tgt        = rd;
               n.skip_edges = 0;
               n.quiet      = 0;
               n.ramping    = 1'b1;
            end
         end
      end else if (ab) begin
         n.ramping = 1'b0;
      end else if (e) begin
         n.quiet = 0;
         if (s.skip_edges != 0) n.skip_edges = s.skip_edges - 1;
         else begin
            n.dv         = toward(s.dv, s.tgt);
            n.skip_edges = SETTLE_PERIODS - 1;
            if (n.dv == s.tgt) begin
               n.done    = 1'b1;
               n.ramping = 1'b0;
            end
         end
      end else if (s.quiet == TIMEOUT - 1) begin
         n.err     = 1'b1;
         n.ramping = 1'b0;
      end else begin
         n.quiet = s.quiet + 1;
      end
      return n;
   endfunction

   // Model advances on the same edges the DUT sees.
   always @(posedge clk_in or posedge rst) begin
      if (rst) ms <= mreset();
      else     ms <= mnext(ms, div_clk_out, req_valid, req_div, abort);
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk_in) begin
      vectors++;
      if (div_val !== ms.dv || req_ready !== !ms.ramping || busy !== ms.ramping ||
          done !== ms.done || err !== ms.err || (done && err)) begin
         miscompares++;
         $display("FAIL model t=%0t div_val=%0d want %0d ready=%b want %b busy=%b want %b done=%b want %b err=%b want %b",
                  $time, div_val, ms.dv, req_ready, !ms.ramping, busy, ms.ramping,
                  done, ms.done, err, ms.err);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs, return just after the edge that consumed them.
   task automatic step(input logic d, input logic rv, input logic [31:0] rd, input logic ab);
      @(negedge clk_in);
      div_clk_out = d;
      req_valid   = rv;
      req_div     = rd;
      abort       = ab;
      @(posedge clk_in);
      #1;
   endtask

   task automatic tick(input logic d);
      step(d, 1'b0, 32'd0, 1'b0);
   endtask

   initial begin
      int n;
      rst         = 1'b1;
      div_clk_out = 1'b0;
      req_valid   = 1'b0;
      req_div     = '0;
      abort       = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("reset div_val", div_val, 4);
      chk("reset req_ready", req_ready, 1);
      chk("reset busy", busy, 0);
      chk("reset done/err", {done, err}, 0);
      rst = 1'b0;

      // Upward ramp 4 -> 8 -> 10, accepted on the first edge after reset.
      step(1'b0, 1'b1, 32'd10, 1'b0);
      chk("up accept busy", busy, 1);
      chk("up accept div_val", div_val, 4);
      tick(1'b1); chk("up edge1 div_val", div_val, 8); chk("up edge1 done", done, 0);
      tick(1'b0); tick(1'b1); chk("up edge2 div_val", div_val, 8);
      tick(1'b0); tick(1'b1);
      chk("up edge3 div_val", div_val, 10);
      chk("up edge3 done", done, 1);
      chk("up edge3 busy", busy, 0);
      tick(1'b0); chk("up done single", done, 0);

      // Downward non-multiple ramp 10 -> 6 -> 3.
      step(1'b0, 1'b1, 32'd3, 1'b0);
      chk("down accept busy", busy, 1);
      tick(1'b1); chk("down edge1 div_val", div_val, 6);
      tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
      chk("down edge3 div_val", div_val, 3);
      chk("down edge3 done", done, 1);
      tick(1'b0);

      // Rejections below DIV_MIN and above DIV_MAX.
      step(1'b0, 1'b1, 32'd1, 1'b0);
      chk("reject1 err", err, 1); chk("reject1 div_val", div_val, 3); chk("reject1 ready", req_ready, 1);
      tick(1'b0); chk("reject1 err pulse", err, 0);
      step(1'b0, 1'b1, 32'd2000, 1'b0);
      chk("reject2000 err", err, 1); chk("reject2000 done", done, 0); chk("reject2000 busy", busy, 0);
      tick(1'b0);

      // Abort coincident with a stepping edge during 4 -> 100.
      @(negedge clk_in); rst = 1'b1;
      @(negedge clk_in); rst = 1'b0;
      step(1'b0, 1'b1, 32'd100, 1'b0);
      tick(1'b1); chk("abort edge1 div_val", div_val, 8);
      tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
      chk("abort edge3 div_val", div_val, 12);
      tick(1'b0); tick(1'b1); tick(1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b1);
      chk("abort div_val", div_val, 12);
      chk("abort busy", busy, 0);
      chk("abort done/err", {done, err}, 0);
      tick(1'b0); chk("abort after done/err", {done, err}, 0);

      // Timeout: one step to 16, then the divider goes quiet.
      step(1'b0, 1'b1, 32'd50, 1'b0);
      tick(1'b1); chk("tmo edge div_val", div_val, 16);
      n = 0;
      do begin
         tick(1'b0);
         n++;
      end while (!err && n < TIMEOUT + 16);
      chk("tmo latency", n, TIMEOUT);
      chk("tmo div_val", div_val, 16);
      chk("tmo busy", busy, 0);

      // Asynchronous reset mid-ramp toward 200.
      step(1'b0, 1'b1, 32'd200, 1'b0);
      tick(1'b1); chk("rst ramp div_val", div_val, 20);
      tick(1'b0);
      @(negedge clk_in); #2 rst = 1'b1; #1;
      chk("rst async div_val", div_val, 4);
      chk("rst async busy", busy, 0);
      @(negedge clk_in); rst = 1'b0;
      chk("rst release ready", req_ready, 1);
      step(1'b0, 1'b1, 32'd200, 1'b0);
      chk("rst first accept busy", busy, 1);

      // Random traffic checked by the model.
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk_in);
         if ($urandom_range(0, 1) == 0) div_clk_out = ~div_clk_out;
         req_valid = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 9))
            0:       req_div = $urandom_range(0, 1);
            1:       req_div = DIV_MAX + $urandom_range(1, 5);
            2:       req_div = $urandom;
            3:       req_div = ms.dv;
            4:       req_div = ($urandom_range(0, 1) == 0) ? DIV_MIN : DIV_MAX;
            default: req_div = $urandom_range(DIV_MIN, 60);
         endcase
         abort = ($urandom_range(0, 24) == 0);
         rst   = ($urandom_range(0, 799) == 0);
      end
      @(negedge clk_in);
      rst       = 1'b0;
      req_valid = 1'b0;
      abort     = 1'b0;
      repeat (2) @(negedge clk_in);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
